// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator for the dual-channel convolution kernel.
// Two line buffers per channel feed a column shift window; stride 1, no padding.
module conv_window_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pix_ch1,
    input  logic [DATA_W-1:0]          in_pix_ch2,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [8:0][DATA_W-1:0]     win_ch1,
    output logic [8:0][DATA_W-1:0]     win_ch2,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    typedef logic [8:0][DATA_W-1:0] win_t;
    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            last_q, last_d;
    logic            vld_q, vld_d;
    logic [RW-1:0]   wrow_q, wrow_d;
    logic [CW-1:0]   wcol_q, wcol_d;
    win_t            wc1_q, wc1_d;
    win_t            wc2_q, wc2_d;

    logic [DATA_W-1:0] lb0_c1_q [0:IMG_W-1];
    logic [DATA_W-1:0] lb1_c1_q [0:IMG_W-1];
    logic [DATA_W-1:0] lb0_c2_q [0:IMG_W-1];
    logic [DATA_W-1:0] lb1_c2_q [0:IMG_W-1];
    win_t              sh1_q, sh2_q;
    win_t              sh1_n, sh2_n;

    logic accept;
    logic emit;
    logic col_last;
    logic row_last;

    // Shift columns left; the new column (top, mid, bottom) enters at c2.
    function automatic win_t shift_in(
        input win_t              w,
        input logic [DATA_W-1:0] t,
        input logic [DATA_W-1:0] m,
        input logic [DATA_W-1:0] b
    );
        win_t n;
        for (int r = 0; r < 3; r++) begin
            n[3*r]   = w[3*r+1];
            n[3*r+1] = w[3*r+2];
        end
        n[2] = t;
        n[5] = m;
        n[8] = b;
        return n;
    endfunction

    assign in_ready   = (state_q == RUN) && !last_q && (!vld_q || win_ready);
    assign accept     = in_valid && in_ready;
    assign col_last   = (col_q == CW'(IMG_W - 1));
    assign row_last   = (row_q == RW'(IMG_H - 1));
    assign emit       = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign frame_done = (state_q == RUN) && last_q && vld_q && win_ready;

    assign sh1_n = shift_in(sh1_q, lb1_c1_q[col_q], lb0_c1_q[col_q], in_pix_ch1);
    assign sh2_n = shift_in(sh2_q, lb1_c2_q[col_q], lb0_c2_q[col_q], in_pix_ch2);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        vld_d   = vld_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        wc1_d   = wc1_q;
        wc2_d   = wc2_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                    last_d  = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_last ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (col_last && row_last) begin
                        last_d = 1'b1;
                    end
                end
                if (emit) begin
                    vld_d  = 1'b1;
                    wc1_d  = sh1_n;
                    wc2_d  = sh2_n;
                    wrow_d = row_q - RW'(2);
                    wcol_d = col_q - CW'(2);
                end else if (vld_q && win_ready) begin
                    vld_d = 1'b0;
                end
                if (frame_done) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wc1_q   <= '0;
            wc2_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wc1_q   <= wc1_d;
            wc2_q   <= wc2_d;
        end
    end

    // Data-path storage: contents are rewritten by rows 0/1 before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            sh1_q           <= sh1_n;
            sh2_q           <= sh2_n;
            lb1_c1_q[col_q] <= lb0_c1_q[col_q];
            lb0_c1_q[col_q] <= in_pix_ch1;
            lb1_c2_q[col_q] <= lb0_c2_q[col_q];
            lb0_c2_q[col_q] <= in_pix_ch2;
        end
    end

    assign win_valid = vld_q;
    assign win_ch1   = wc1_q;
    assign win_ch2   = wc2_q;
    assign win_row   = wrow_q;
    assign win_col   = wcol_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 4x4 and 6-row x 5-col instances share stimulus;
// expected windows come from a frame-level reference built from the image arrays.
module tb_conv_window_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic start4, start56;
    logic in_valid, win_ready;
    logic [15:0] pix1, pix2;
    logic sel;

    logic a_rdy, a_vld, a_busy, a_fd;
    logic [8:0][15:0] a_w1, a_w2;
    logic [1:0] a_row, a_col;
    logic b_rdy, b_vld, b_busy, b_fd;
    logic [8:0][15:0] b_w1, b_w2;
    logic [2:0] b_row, b_col;

    logic in_ready, win_valid, busy, fdone, other_rdy;
    logic [143:0] w1, w2;
    logic [7:0] wrow, wcol;

    logic [15:0] img1 [0:7][0:7];
    logic [15:0] img2 [0:7][0:7];
    logic [143:0] cap_first1, cap_first2, cap_last1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .in_valid(in_valid), .in_ready(a_rdy),
        .in_pix_ch1(pix1), .in_pix_ch2(pix2),
        .win_valid(a_vld), .win_ready(win_ready),
        .win_ch1(a_w1), .win_ch2(a_w2),
        .win_row(a_row), .win_col(a_col),
        .busy(a_busy), .frame_done(a_fd)
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(6), .DATA_W(16)) u_dut56 (
        .clk(clk), .rst_n(rst_n), .start(start56),
        .in_valid(in_valid), .in_ready(b_rdy),
        .in_pix_ch1(pix1), .in_pix_ch2(pix2),
        .win_valid(b_vld), .win_ready(win_ready),
        .win_ch1(b_w1), .win_ch2(b_w2),
        .win_row(b_row), .win_col(b_col),
        .busy(b_busy), .frame_done(b_fd)
    );

    always_comb begin
        if (sel) begin
            in_ready  = b_rdy;
            win_valid = b_vld;
            busy      = b_busy;
            fdone     = b_fd;
            w1        = b_w1;
            w2        = b_w2;
            wrow      = 8'(b_row);
            wcol      = 8'(b_col);
            other_rdy = a_rdy;
        end else begin
            in_ready  = a_rdy;
            win_valid = a_vld;
            busy      = a_busy;
            fdone     = a_fd;
            w1        = a_w1;
            w2        = a_w2;
            wrow      = 8'(a_row);
            wcol      = 8'(a_col);
            other_rdy = b_rdy;
        end
    end

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, fdone, 0);
        chk({tag, "_win_ch1"}, w1, 0);
        chk({tag, "_win_ch2"}, w2, 0);
        chk({tag, "_win_row"}, wrow, 0);
        chk({tag, "_win_col"}, wcol, 0);
    endtask

    task automatic run_frame(input int w, input int h, input bit rnd,
                             input int vpct, input int stall_win,
                             input int stall_len, input int start_mid,
                             input int rst_after);
        logic [143:0] q1[$];
        logic [143:0] q2[$];
        int qr[$];
        int qc[$];
        logic [143:0] e1, e2;
        int pix, cyc, nwin, stalled, total;
        bit done, exp_new, hs, last_acc;
        pix = 0; cyc = 0; nwin = 0; stalled = 0;
        done = 0; exp_new = 0; last_acc = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                img1[r][c] = rnd ? 16'($urandom) : 16'(256 * r + c);
                img2[r][c] = rnd ? 16'($urandom) : (img1[r][c] | 16'h8000);
            end
        for (int r = 0; r <= h - 3; r++)
            for (int c = 0; c <= w - 3; c++) begin
                for (int k = 0; k < 9; k++) begin
                    e1[16*k +: 16] = img1[r + k/3][c + k%3];
                    e2[16*k +: 16] = img2[r + k/3][c + k%3];
                end
                q1.push_back(e1); q2.push_back(e2);
                qr.push_back(r);  qc.push_back(c);
            end
        total = (h - 2) * (w - 2);

        @(negedge clk);
        in_valid = 0; win_ready = 1;
        if (sel) start56 = 1; else start4 = 1;
        #1 chk("pre_start_busy", busy, 0);
        @(negedge clk);
        start4 = 0; start56 = 0;
        chk("busy_after_start", busy, 1);

        while (!done && cyc < 3000) begin
            in_valid = (pix < w*h) && ($urandom_range(99) < vpct);
            if (pix < w*h) begin
                pix1 = img1[pix / w][pix % w];
                pix2 = img2[pix / w][pix % w];
            end
            win_ready = !(win_valid && nwin == stall_win && stalled < stall_len);
            if (cyc == start_mid) begin
                start4 = !sel; start56 = sel;
            end else begin
                start4 = 0; start56 = 0;
            end
            #1;
            chk("other_in_ready", other_rdy, 0);
            if (exp_new) chk("latency", win_valid, 1);
            exp_new = 0;
            if (win_valid) begin
                if (q1.size() == 0) begin
                    chk("extra_window", win_valid, 0);
                end else begin
                    chk("win_ch1", w1, q1[0]);
                    chk("win_ch2", w2, q2[0]);
                    chk("win_row", wrow, qr[0]);
                    chk("win_col", wcol, qc[0]);
                end
            end
            if (win_valid && !win_ready) begin
                chk("stall_in_ready", in_ready, 0);
                stalled++;
            end
            if (last_acc) chk("in_ready_after_last", in_ready, 0);
            hs = win_valid && win_ready;
            chk("frame_done", fdone, hs && nwin == total - 1);
            if (hs) begin
                if (nwin == 0) begin
                    cap_first1 = w1; cap_first2 = w2;
                end
                cap_last1 = w1;
                if (q1.size() > 0) begin
                    void'(q1.pop_front()); void'(q2.pop_front());
                    void'(qr.pop_front()); void'(qc.pop_front());
                end
                nwin++;
            end
            if (fdone) done = 1;
            if (in_valid && in_ready) begin
                if (pix / w >= 2 && pix % w >= 2) exp_new = 1;
                pix++;
                if (pix == w*h) last_acc = 1;
                if (rst_after > 0 && pix == rst_after) begin
                    @(posedge clk);
                    @(negedge clk);
                    rst_n = 0; in_valid = 0; start4 = 0; start56 = 0;
                    #1 chk_reset_vals("mid_reset");
                    @(negedge clk);
                    rst_n = 1;
                    return;
                end
            end
            @(posedge clk);
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        chk("frame_completed", done, 1);
        chk("win_count", nwin, total);
        chk("stall_cycles", stalled, (stall_win >= 0) ? stall_len : 0);
    endtask

    initial begin
        rst_n = 0; sel = 0; start4 = 0; start56 = 0;
        in_valid = 0; win_ready = 1; pix1 = 0; pix2 = 0;
        repeat (3) @(negedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1;

        // in_valid while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1; pix1 = 16'hdead; pix2 = 16'hbeef;
            #1 chk("idle_in_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
        end
        @(negedge clk);
        in_valid = 0;

        // basic 4x4 frame
        run_frame(4, 4, 0, 100, -1, 0, -1, 0);
        chk("w00_ch1_const", cap_first1,
            144'h0202_0201_0200_0102_0101_0100_0002_0001_0000);
        chk("w00_ch2_const", cap_first2,
            144'h8202_8201_8200_8102_8101_8100_8002_8001_8000);
        // back-to-back frame with fresh data
        run_frame(4, 4, 1, 100, -1, 0, -1, 0);
        repeat (3) @(negedge clk);

        // backpressure at window (0,1)
        run_frame(4, 4, 0, 100, 1, 5, -1, 0);
        chk("w11_ch1_const", cap_last1,
            144'h0303_0302_0301_0203_0202_0201_0103_0102_0101);
        repeat (2) @(negedge clk);

        // start pulse while busy
        run_frame(4, 4, 1, 70, -1, 0, 5, 0);
        repeat (2) @(negedge clk);

        // bubbly input on the larger frame
        sel = 1;
        run_frame(5, 6, 1, 50, -1, 0, -1, 0);
        repeat (2) @(negedge clk);

        // reset mid-frame, then a clean frame
        sel = 0;
        run_frame(4, 4, 1, 100, -1, 0, -1, 7);
        run_frame(4, 4, 0, 100, -1, 0, -1, 0);
        chk("post_reset_w00", cap_first1,
            144'h0202_0201_0200_0102_0101_0100_0002_0001_0000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that feeds the dual-channel convolution kernel. Accepts a raster-ordered stream of FP16 pixel pairs (channel 1 and channel 2), buffers two image lines per channel, and emits one pair of 3x3 windows per valid output position: stride 1, no padding. The `win_ch1`/`win_ch2` outputs connect directly to the kernel's `ifmap_1`/`ifmap_2` inputs. Pixel data is opaque 16-bit; no arithmetic is performed on it.

## Interface
- `IMG_W`, 32: image width in pixels; must be ≥ 3.
- `IMG_H`, 32: image height in pixels; must be ≥ 3.
- `DATA_W`, 16: pixel width (FP16 bit pattern).

Ports:
- `clk`  in  1  single clock; all logic rises on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a frame; ignored unless the block is in IDLE.
- `in_valid`  in  1  pixel pair valid.
- `in_ready`  out  1  block can accept a pixel pair.
- `in_pix_ch1`, `in_pix_ch2`  in  DATA_W each  pixel at the current raster position.
- `win_valid`  out  1  window pair valid.
- `win_ready`  in  1  consumer accepts the window pair.
- `win_ch1`, `win_ch2`  out  [8:0][DATA_W-1:0] each  3x3 windows; element i = 3*r + c; r=0 is the top (oldest) row; c=0 is the left column.
- `win_row`  out  $clog2(IMG_H)  top-left row of the current window.
- `win_col`  out  $clog2(IMG_W)  top-left column of the current window.
- `busy`  out  1  high in RUN.
- `frame_done`  out  1  one-cycle pulse at the end of the frame.

## Operation
- FSM states are IDLE and RUN.
- IDLE → RUN on `start`.
- RUN → IDLE in the cycle the last window handshakes.
- Row and column input counters (`row`, `col`) reset to 0 on `start`.
- A pixel is accepted when `in_valid && in_ready`. On acceptance:
  - `col` increments and wraps to 0 at IMG_W-1; `row` increments on wrap.
  - Per channel, the incoming column {lb1[col], lb0[col], pix} is shifted into a 3x3 window register. lb1 is the older line, lb0 the newer one.
  - The shift moves c2→c1→c0, and the new column enters at c2.
  - Then lb1[col] ← lb0[col] and lb0[col] ← pix.
- The output register loads the window, `win_row = row-2`, `win_col = col-2`, and sets `win_valid`, when the accepted pixel has row ≥ 2 and col ≥ 2. Other accepted pixels update only the line buffers and the shift window.
- Stale columns after a row wrap are never emitted, because windows are gated by col ≥ 2.
- `win_valid` clears on `win_ready` unless a new window loads in the same cycle.
- Backpressure: `in_ready = (state==RUN) && !last_accepted && (!win_valid || win_ready)`. The single output stage never overflows.
- After the pixel at (IMG_H-1, IMG_W-1) is accepted, `last_accepted` sets and `in_ready` stays low until IDLE.
- Total windows per frame: (IMG_H-2)*(IMG_W-2).
- `frame_done` pulses in the cycle the final window handshakes. `busy` drops in the following cycle.
- `start` during RUN is ignored. `in_valid` in IDLE is ignored, with `in_ready` = 0.
- Line-buffer contents are don't-care at frame start. Rows 0 and 1 fully overwrite them before the first emission.
- Reset mid-frame: return to IDLE immediately, clear all counters and control flags, and drop any pending window with no `frame_done`.

## Timing
- Values held by reset: `in_ready`, `win_valid`, `busy` and `frame_done` are 0. `win_ch1`, `win_ch2`, `win_row` and `win_col` are 0.
- Latency: `win_valid` rises 1 cycle after acceptance of the window's bottom-right pixel.
- Throughput: 1 pixel/cycle with `win_ready` held high. Windows are produced back-to-back within a row, with IMG_W-(IMG_W-2) = 2 window-free pixels per row.
- `win_ch*`, `win_row` and `win_col` are stable while `win_valid && !win_ready`.
- The kernel downstream adds its own pipeline latency. This block does not account for it.

## Test plan
- **Basic 4x4 frame:** IMG_W=IMG_H=4, ch1 pixel = 16'h0100*r + c, ch2 = ch1 | 16'h8000, `win_ready`=1.
  - Exactly 4 windows arrive, in order (0,0), (0,1), (1,0), (1,1).
  - Window (0,0) ch1 = {0000,0001,0002,0100,0101,0102,0200,0201,0202} for indices 0..8.
  - `frame_done` pulses once, with the 4th window.
- **Backpressure:** same frame with `win_ready` low for 5 cycles at window (0,1).
  - `in_ready` = 0 throughout the stall.
  - The window holds stable.
  - No window is lost or duplicated; window (1,1) ch1 = {0101,0102,0103,0201,0202,0203,0301,0302,0303}.
- **Bubbly input:** `in_valid` random 50% on a 5x6 frame.
  - 12 windows arrive, each matching the reference model.
  - `win_row`/`win_col` are correct for every window.
- **Back-to-back frames:** `start` issued in the cycle after `frame_done`.
  - The second frame (different data) produces correct windows, with no leakage from the first frame's line buffers.
- **Control edge cases:**
  - `start` while `busy` → ignored, with the window count unchanged.
  - `in_valid` in IDLE → `in_ready` = 0 and nothing is accepted.
- **Reset mid-frame:** assert `rst_n` low after 7 accepted pixels.
  - All outputs go to their reset values immediately.
  - A subsequent full 4x4 frame produces the 4 correct windows.
